mcp3008_responder: RTL and testbench
====================================

// Module: mcp3008_responder
// PURPOSE
//  Synthesizable MCP3008 ADC emulator: SPI responder for the 4-wire link our ADC master drives.
//  Oversamples dclk/cs_n/din on the system clock, decodes start + SGL/DIFF + D2..D0, returns
//  a null bit, then 10-bit data MSB-first, then LSB-first repeat, then zeros.
//  Used for hardware-in-loop and bench checks of the CCD readout chain without a real ADC.
// PARAMETERS
//  SYNC_STAGES  2   synchronizer flops on dclk, cs_n and din (>=2)
//  RES          10  sample width in bits
//  NUM_CH       8   channel count; ch_data holds NUM_CH*RES bits
// PORTS
//  clk         in   1       system clock; must be >= 8x dclk frequency
//  rst         in   1       synchronous, active-high reset
//  dclk        in   1       SPI clock from master, asynchronous to clk
//  cs_n        in   1       active-low chip select from master, asynchronous
//  din         in   1       master-to-ADC serial data, asynchronous
//  dout        out  1       ADC-to-master serial data
//  dout_oe     out  1       1 = drive dout on the pad; 0 = release (tri-state at top level)
//  ch_data     in   NUM_CH*RES  per-channel sample values; channel k at [k*RES +: RES]
//  cfg_sgl     out  1       SGL/DIFF bit of the last decoded request
//  cfg_ch      out  3       D2..D0 of the last decoded request
//  cfg_valid   out  1       1-clk pulse when D0 is captured
//  frame_done  out  1       1-clk pulse when B0 (MSB-first pass) has been shifted out
//  abort       out  1       1-clk pulse when cs_n rises before frame_done in the same frame
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, shift regs 0. Reset mid-frame releases dout at once.
//  Input path: SYNC_STAGES flops per input, plus one history flop. rise/fall = 1-clk strobes.
//  Edge-to-action latency is SYNC_STAGES+1 clk cycles.
//  Sampling: din is sampled on a dclk rise strobe; dout/dout_oe change only on a dclk fall strobe,
//  except where cs_n rules below apply.
//  cs_n high (synchronized) has priority over everything. State becomes IDLE and dout_oe=0 on
//  the same cycle. If the state was not IDLE and frame_done had not fired, abort pulses.
//  cs_n fall moves IDLE -> WAIT_START. dout_oe stays 0.
//  States (bit counter cnt, 4 bits):
//   IDLE        waiting for cs_n low.
//   WAIT_START  din=0 on a rise: stay. din=1 on a rise: go to CFG, cnt=0.
//               Leading zeros before the start bit are legal.
//   CFG         each rise shifts din into {sgl,d2,d1,d0}; cnt++.
//               On the 4th rise: update cfg_sgl/cfg_ch, pulse cfg_valid, latch
//               ch_data[{d2,d1,d0}*RES +: RES] into the sample reg, go to NULL.
//   NULL        next fall: dout_oe=1, dout=0; go to MSB, cnt=RES-1.
//   MSB         each fall: dout=sample[cnt]. At cnt=0, pulse frame_done, go to LSB with cnt=1.
//               Otherwise cnt--.
//   LSB         each fall: dout=sample[cnt]; cnt++. After sample[RES-1] is output, go to ZERO.
//   ZERO        each fall: dout=0 until cs_n rises.
//  Sample reg latches exactly once per frame; later ch_data changes do not affect the frame.
//  A rise and a fall strobe in the same clk is impossible when clk >= 8x dclk. Behaviour in
//  that case is undefined and not tested.
//  SGL/DIFF does not alter data: ch_data already holds the value to return.
//  A new cs_n fall after IDLE starts a fresh frame; there is no carry-over.
// STRUCTURE
//  mcp3008_defs.vh holds state localparams (IDLE, WAIT_START, CFG, NULL, MSB, LSB, ZERO),
//  CFG_BITS=4 and the default RES=10. Shared with the master-side interface.
//  Sub-module spi_edge_sync (SYNC_STAGES parameter) has ports clk, rst, async_in,
//  sync_out, rise, fall. It is instantiated once each for dclk, cs_n and din.
//  The top holds the FSM, cfg/sample registers and output flops. dout and dout_oe are registered.
// TESTING
//  1 ch_data ch0=10'h2A5; master sends 5'b10000 -> cfg_sgl=0, cfg_ch=0, one cfg_valid;
//    dout after the null bit = 1010100101, frame_done once, no abort.
//  2 Request 5'b11101 (SGL, ch5=10'h001) -> cfg_ch=5, cfg_sgl=1; MSB bits 0000000001.
//    With 10 more clocks: LSB pass 000000000, then zeros.
//  3 Two leading zeros before the start bit -> identical response to scenario 1, shifted by 2 dclks.
//  4 cs_n rises after 3 data bits -> abort pulses once, dout_oe=0 within SYNC_STAGES+1 clk,
//    no frame_done; next frame is correct.
//  5 Change ch0 from 10'h2A5 to 10'h3FF during MSB output -> the frame still returns 10'h2A5.
//  6 Assert rst mid-MSB -> all outputs 0 on the next clk; a following full frame is correct.

Source files
------------

// File: rtl/mcp3008_responder_pkg.sv
// rtl/mcp3008_responder_pkg.sv - shared constants and FSM state type for the MCP3008 responder
package mcp3008_responder_pkg;

  localparam int CFG_BITS = 4;
  localparam int DEF_RES  = 10;
  localparam int CNT_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_CFG,
    ST_NULL,
    ST_MSB,
    ST_LSB,
    ST_ZERO
  } state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - multi-flop synchronizer with one-clock rise/fall strobes
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~hist_q;
  assign fall     = ~sync_out & hist_q;

endmodule

// File: rtl/mcp3008_responder.sv
// rtl/mcp3008_responder.sv - MCP3008 ADC emulator: oversampled SPI responder returning ch_data samples
module mcp3008_responder
  import mcp3008_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RES         = DEF_RES,
  parameter int NUM_CH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dclk,
  input  logic                  cs_n,
  input  logic                  din,
  output logic                  dout,
  output logic                  dout_oe,
  input  logic [NUM_CH*RES-1:0] ch_data,
  output logic                  cfg_sgl,
  output logic [2:0]            cfg_ch,
  output logic                  cfg_valid,
  output logic                  frame_done,
  output logic                  abort
);

  logic dclk_lvl, dclk_rise, dclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic din_lvl, din_rise, din_fall;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dclk (
    .clk(clk), .rst(rst), .async_in(dclk),
    .sync_out(dclk_lvl), .rise(dclk_rise), .fall(dclk_fall)
  );
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .async_in(cs_n),
    .sync_out(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .clk(clk), .rst(rst), .async_in(din),
    .sync_out(din_lvl), .rise(din_rise), .fall(din_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, dclk_lvl, cs_rise, din_rise, din_fall};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CFG_BITS-2:0] cfg_sr_q, cfg_sr_d;
  logic [CFG_BITS-1:0] cfg_full;
  logic [RES-1:0]      sample_q, sample_d;
  logic                dout_q, dout_d, oe_q, oe_d;
  logic                sgl_q, sgl_d;
  logic [2:0]          ch_q, ch_d;
  logic                cv_q, cv_d, fd_q, fd_d, ab_q, ab_d;
  logic                done_seen_q, done_seen_d;

  assign cfg_full = {cfg_sr_q, din_lvl};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cfg_sr_d    = cfg_sr_q;
    sample_d    = sample_q;
    dout_d      = dout_q;
    oe_d        = oe_q;
    sgl_d       = sgl_q;
    ch_d        = ch_q;
    cv_d        = 1'b0;
    fd_d        = 1'b0;
    ab_d        = 1'b0;
    done_seen_d = done_seen_q;
    // Deasserted chip select overrides every state and releases the pad immediately.
    if (cs_lvl) begin
      state_d     = ST_IDLE;
      oe_d        = 1'b0;
      dout_d      = 1'b0;
      ab_d        = (state_q != ST_IDLE) && !done_seen_q;
      done_seen_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall) state_d = ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (dclk_rise && din_lvl) begin
            state_d = ST_CFG;
            cnt_d   = '0;
          end
        end
        ST_CFG: begin
          if (dclk_rise) begin
            cfg_sr_d = cfg_full[CFG_BITS-2:0];
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(CFG_BITS - 1)) begin
              sgl_d    = cfg_full[CFG_BITS-1];
              ch_d     = cfg_full[2:0];
              cv_d     = 1'b1;
              sample_d = ch_data[int'(cfg_full[2:0])*RES +: RES];
              state_d  = ST_NULL;
            end
          end
        end
        ST_NULL: begin
          if (dclk_fall) begin
            oe_d    = 1'b1;
            dout_d  = 1'b0;
            state_d = ST_MSB;
            cnt_d   = CNT_W'(RES - 1);
          end
        end
        ST_MSB: begin
          if (dclk_fall) begin
            dout_d = sample_q[cnt_q];
            if (cnt_q == '0) begin
              fd_d        = 1'b1;
              done_seen_d = 1'b1;
              state_d     = ST_LSB;
              cnt_d       = CNT_W'(1);
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        ST_LSB: begin
          if (dclk_fall) begin
            dout_d = sample_q[cnt_q];
            if (cnt_q == CNT_W'(RES - 1)) state_d = ST_ZERO;
            else                          cnt_d   = cnt_q + 1'b1;
          end
        end
        ST_ZERO: begin
          if (dclk_fall) dout_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cfg_sr_q    <= '0;
      sample_q    <= '0;
      dout_q      <= 1'b0;
      oe_q        <= 1'b0;
      sgl_q       <= 1'b0;
      ch_q        <= '0;
      cv_q        <= 1'b0;
      fd_q        <= 1'b0;
      ab_q        <= 1'b0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_sr_q    <= cfg_sr_d;
      sample_q    <= sample_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      sgl_q       <= sgl_d;
      ch_q        <= ch_d;
      cv_q        <= cv_d;
      fd_q        <= fd_d;
      ab_q        <= ab_d;
      done_seen_q <= done_seen_d;
    end
  end

  assign dout       = dout_q;
  assign dout_oe    = oe_q;
  assign cfg_sgl    = sgl_q;
  assign cfg_ch     = ch_q;
  assign cfg_valid  = cv_q;
  assign frame_done = fd_q;
  assign abort      = ab_q;

endmodule

// File: tb/tb_mcp3008_responder.sv
// tb/tb_mcp3008_responder.sv - self-checking bench for mcp3008_responder
module tb_mcp3008_responder;

  localparam int RES    = 10;
  localparam int NUM_CH = 8;
  localparam int H      = 50;
  localparam int NBITS  = 26;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  dclk = 1'b0;
  logic                  cs_n = 1'b1;
  logic                  din = 1'b0;
  logic                  dout, dout_oe, cfg_sgl, cfg_valid, frame_done, abort;
  logic [2:0]            cfg_ch;
  logic [NUM_CH*RES-1:0] ch_data = '0;

  int tests = 0;
  int fails = 0;
  int n_cv  = 0;
  int n_fd  = 0;
  int n_ab  = 0;

  always #5 clk = ~clk;

  mcp3008_responder #(.SYNC_STAGES(2), .RES(RES), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst), .dclk(dclk), .cs_n(cs_n), .din(din),
    .dout(dout), .dout_oe(dout_oe), .ch_data(ch_data),
    .cfg_sgl(cfg_sgl), .cfg_ch(cfg_ch), .cfg_valid(cfg_valid),
    .frame_done(frame_done), .abort(abort)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_valid)  n_cv = n_cv + 1;
      if (frame_done) n_fd = n_fd + 1;
      if (abort)      n_ab = n_ab + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read order seen by the master: null, MSB-first sample, LSB-first repeat without B0, zeros.
  function automatic logic [NBITS-1:0] model(input logic [RES-1:0] s);
    logic [NBITS-1:0] m;
    m = '0;
    for (int k = 1; k <= RES; k++)       m[k] = s[RES-k];
    for (int k = RES+1; k < 2*RES; k++)  m[k] = s[k-RES];
    return m;
  endfunction

  task automatic send_bit(input logic b);
    din = b;
    #H dclk = 1'b1;
    #H dclk = 1'b0;
  endtask

  task automatic start_frame(input int nlead, input logic sgl, input logic [2:0] ch);
    cs_n = 1'b0;
    #H;
    for (int i = 0; i < nlead; i++) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(sgl);
    send_bit(ch[2]);
    send_bit(ch[1]);
    send_bit(ch[0]);
    din = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    #H dclk = 1'b1;
    b = dout;
    #H dclk = 1'b0;
  endtask

  task automatic end_frame(input string tag);
    #H cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check({tag, "_oe_off"}, 32'(dout_oe), 32'd0);
    #(2*H);
  endtask

  task automatic run_frame(input string tag, input int nlead, input logic sgl, input logic [2:0] ch,
                           input int chg_at, input logic [RES-1:0] chg_val);
    logic [NBITS-1:0] exp_s, obs_s;
    logic b;
    int cv0, fd0, ab0;
    exp_s = model(ch_data[int'(ch)*RES +: RES]);
    cv0 = n_cv; fd0 = n_fd; ab0 = n_ab;
    start_frame(nlead, sgl, ch);
    for (int k = 0; k < NBITS; k++) begin
      read_bit(b);
      obs_s[k] = b;
      if (k == 0) check({tag, "_oe_on"}, 32'(dout_oe), 32'd1);
      if (k == chg_at) ch_data[int'(ch)*RES +: RES] = chg_val;
    end
    check({tag, "_stream"}, 32'(obs_s), 32'(exp_s));
    check({tag, "_cfg_sgl"}, 32'(cfg_sgl), 32'(sgl));
    check({tag, "_cfg_ch"}, 32'(cfg_ch), 32'(ch));
    check({tag, "_cfg_valid_n"}, 32'(n_cv - cv0), 32'd1);
    check({tag, "_frame_done_n"}, 32'(n_fd - fd0), 32'd1);
    end_frame(tag);
    check({tag, "_abort_n"}, 32'(n_ab - ab0), 32'd0);
  endtask

  initial begin
    logic b;
    int fd0, ab0;
    for (int i = 0; i < NUM_CH; i++) ch_data[i*RES +: RES] = RES'($urandom);

    rst = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("reset_outputs", 32'({dout, dout_oe, cfg_sgl, cfg_ch, cfg_valid, frame_done, abort}), 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #2;

    ch_data[0*RES +: RES] = 10'h2A5;
    run_frame("s1_ch0", 0, 1'b0, 3'd0, -1, '0);

    ch_data[5*RES +: RES] = 10'h001;
    run_frame("s2_ch5_sgl", 0, 1'b1, 3'd5, -1, '0);

    run_frame("s3_lead2", 2, 1'b0, 3'd0, -1, '0);

    fd0 = n_fd; ab0 = n_ab;
    start_frame(0, 1'b0, 3'd3);
    repeat (4) read_bit(b);
    check("s4_oe_mid", 32'(dout_oe), 32'd1);
    end_frame("s4");
    check("s4_abort_n", 32'(n_ab - ab0), 32'd1);
    check("s4_frame_done_n", 32'(n_fd - fd0), 32'd0);
    run_frame("s4_next", 0, 1'b0, 3'd3, -1, '0);

    ch_data[0*RES +: RES] = 10'h2A5;
    run_frame("s5_change", 0, 1'b0, 3'd0, 4, 10'h3FF);
    run_frame("s5_after", 1, 1'b1, 3'd0, -1, '0);

    fd0 = n_fd; ab0 = n_ab;
    start_frame(0, 1'b0, 3'd2);
    repeat (4) read_bit(b);
    check("s6_oe_before", 32'(dout_oe), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("s6_reset_outputs", 32'({dout, dout_oe, cfg_sgl, cfg_ch, cfg_valid, frame_done, abort}), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    cs_n = 1'b1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("s6_abort_n", 32'(n_ab - ab0), 32'd0);
    check("s6_frame_done_n", 32'(n_fd - fd0), 32'd0);
    run_frame("s6_next", 0, 1'b1, 3'd2, -1, '0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NUM_CH; i++) ch_data[i*RES +: RES] = RES'($urandom);
      run_frame($sformatf("rand%0d", r), int'($urandom_range(0, 3)), 1'($urandom),
                3'($urandom_range(0, 7)), -1, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
